// File: rtl/hamming_secded_pipe_if.sv
// Valid/ready bundle for the SECDED decode pipeline: codeword in, corrected result out.
// The master drives codewords and accepts results; the decoder is the slave.
interface hamming_secded_pipe_if #(
   parameter int unsigned DATA_W = 8
);

   function automatic int unsigned calc_chk_w(input int unsigned dw);
      int unsigned k;
      k = 1;
      while ((32'd1 << k) < dw + k + 1) k = k + 1;
      return k;
   endfunction

   localparam int unsigned CHK_W = calc_chk_w(DATA_W);
   localparam int unsigned CW_W  = DATA_W + CHK_W + 1;

   logic              in_valid;
   logic              in_ready;
   logic [CW_W-1:0]   in_cw;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CHK_W-1:0]  out_syndrome;
   logic              single_bit_ERROR;
   logic              two_bit_ERROR;

   modport master (
      output in_valid,
      output in_cw,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_syndrome,
      input  single_bit_ERROR,
      input  two_bit_ERROR
   );

   modport slave (
      input  in_valid,
      input  in_cw,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_syndrome,
      output single_bit_ERROR,
      output two_bit_ERROR
   );

endinterface

// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED decoder: stage 1 registers syndrome/parity, stage 2 classifies and corrects.
// Full valid/ready backpressure plus saturating SEC/DED event counters.
module hamming_secded_pipe #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   hamming_secded_pipe_if.slave bus,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     sec_count,
   output logic [CNT_W-1:0]     ded_count
);

   function automatic int unsigned calc_chk_w(input int unsigned dw);
      int unsigned k;
      k = 1;
      while ((32'd1 << k) < dw + k + 1) k = k + 1;
      return k;
   endfunction

   // Codeword position of payload bit d: the (d+1)-th non-power-of-two position.
   function automatic int unsigned data_pos(input int unsigned d);
      int unsigned p;
      int unsigned n;
      p = 0;
      n = 0;
      while (n <= d) begin
         p = p + 1;
         if ((p & (p - 1)) != 0) n = n + 1;
      end
      return p;
   endfunction

   localparam int unsigned      CHK_W  = calc_chk_w(DATA_W);
   localparam int unsigned      CW_W   = DATA_W + CHK_W + 1;
   localparam logic [CHK_W-1:0] MaxPos = CHK_W'(DATA_W + CHK_W);

   // Stage 1 state
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [CHK_W-1:0]  s1_syn_q, s1_syn_d;
   logic              s1_par_q, s1_par_d;

   // Stage 2 (output) state
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [CHK_W-1:0]  out_syn_q, out_syn_d;
   logic              sec_flag_q, sec_flag_d;
   logic              ded_flag_q, ded_flag_d;

   logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
   logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;

   logic              s2_load;
   logic              s1_load;
   logic              out_fire;

   logic [CHK_W-1:0]  syn_c;
   logic              par_c;
   logic [DATA_W-1:0] raw_data;
   logic [DATA_W-1:0] flip;
   logic              syn_zero;
   logic              in_range;
   logic              fix;
   logic              sec_c;
   logic              ded_c;

   assign s2_load     = !out_valid_q || bus.out_ready;
   assign s1_load     = !s1_valid_q || s2_load;
   assign out_fire    = out_valid_q && bus.out_ready;
   assign bus.in_ready = s1_load;

   always_comb begin
      syn_c = '0;
      for (int unsigned p = 1; p < CW_W; p++) begin
         if (bus.in_cw[p]) syn_c = syn_c ^ CHK_W'(p);
      end
      par_c = ^bus.in_cw;
   end

   // Only payload positions are carried forward; check bits matter only via the syndrome.
   for (genvar g = 0; g < DATA_W; g++) begin : g_data
      localparam int unsigned Pos = data_pos(g);
      assign raw_data[g] = bus.in_cw[Pos];
      assign flip[g]     = fix && (s1_syn_q == CHK_W'(Pos));
   end

   assign syn_zero = (s1_syn_q == '0);
   assign in_range = (s1_syn_q <= MaxPos);
   assign fix      = !syn_zero && s1_par_q && in_range;
   assign sec_c    = s1_par_q && (syn_zero || in_range);
   assign ded_c    = !syn_zero && (!s1_par_q || !in_range);

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_syn_d   = s1_syn_q;
      s1_par_d   = s1_par_q;
      if (s1_load) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_data_d = raw_data;
            s1_syn_d  = syn_c;
            s1_par_d  = par_c;
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_syn_d   = out_syn_q;
      sec_flag_d  = sec_flag_q;
      ded_flag_d  = ded_flag_q;
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = s1_data_q ^ flip;
            out_syn_d  = s1_syn_q;
            sec_flag_d = sec_c;
            ded_flag_d = ded_c;
         end
      end
   end

   // Clear has priority over a same-cycle increment; counts stick at all-ones.
   always_comb begin
      sec_cnt_d = sec_cnt_q;
      ded_cnt_d = ded_cnt_q;
      if (cnt_clr) begin
         sec_cnt_d = '0;
         ded_cnt_d = '0;
      end else if (out_fire) begin
         if (sec_flag_q && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + CNT_W'(1);
         if (ded_flag_q && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_syn_q    <= '0;
         s1_par_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_syn_q   <= '0;
         sec_flag_q  <= 1'b0;
         ded_flag_q  <= 1'b0;
         sec_cnt_q   <= '0;
         ded_cnt_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_syn_q    <= s1_syn_d;
         s1_par_q    <= s1_par_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_syn_q   <= out_syn_d;
         sec_flag_q  <= sec_flag_d;
         ded_flag_q  <= ded_flag_d;
         sec_cnt_q   <= sec_cnt_d;
         ded_cnt_q   <= ded_cnt_d;
      end
   end

   assign bus.out_valid        = out_valid_q;
   assign bus.out_data         = out_data_q;
   assign bus.out_syndrome     = out_syn_q;
   assign bus.single_bit_ERROR = sec_flag_q;
   assign bus.two_bit_ERROR    = ded_flag_q;
   assign sec_count            = sec_cnt_q;
   assign ded_count            = ded_cnt_q;

endmodule
